// File: rtl/memory_burst_agu_if.sv
// Memory request/acknowledge bus between the burst AGU and memory.
// The AGU drives the request and address; memory returns the ack.
interface memory_burst_agu_if #(
   parameter int WORD = 16
);
   logic            mem_req_o;
   logic [WORD-1:0] mem_addr_o;
   logic            mem_ack_i;

   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_ack_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_ack_i
   );
endinterface

// File: rtl/memory_burst_agu.sv
// Sequenced auto-stepping burst address generator with pointer write-back.
// Optional macro ALIGN_CHECK_EN aborts misaligned +/-2 word bursts with err_o.
module memory_burst_agu #(
   parameter  int WORD      = 16,
   parameter  int MAX_BURST = 4,
   localparam int CW        = $clog2(MAX_BURST + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WORD-1:0]  base_i,
   input  logic [WORD-1:0]  offset_i,
   input  logic [2:0]       sel_i,
   input  logic             pre_i,
   input  logic [CW-1:0]    count_i,
   memory_burst_agu_if.master mem,
   output logic             busy_o,
   output logic             done_o,
   output logic             wb_en_o,
   output logic [WORD-1:0]  wb_addr_o,
   output logic             err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_CHK   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [WORD-1:0] addr_q, addr_d;
   logic [WORD-1:0] step_q, step_d;
   logic            pre_q, pre_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic [WORD-1:0] wb_q, wb_d;

   logic [WORD-1:0] step_sel;
   logic [WORD-1:0] first_addr;
   logic [CW-1:0]   cnt_norm;

   always_comb begin
      step_sel = '0;
      case (sel_i)
         3'd0:    step_sel = WORD'(2);
         3'd1:    step_sel = WORD'(1);
         3'd2:    step_sel = ~WORD'(1);
         3'd3:    step_sel = '1;
         3'd4:    step_sel = offset_i;
         default: step_sel = '0;
      endcase
   end

   assign first_addr = pre_i ? base_i + step_sel : base_i;

   always_comb begin
      cnt_norm = count_i;
      if (count_i == '0)
         cnt_norm = CW'(1);
      else if (count_i > CW'(MAX_BURST))
         cnt_norm = CW'(MAX_BURST);
   end

`ifdef ALIGN_CHECK_EN
   logic err_q, err_d;
   logic misaligned;

   assign misaligned = ((sel_i == 3'd0) || (sel_i == 3'd2)) && first_addr[0];
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      step_d  = step_q;
      pre_d   = pre_q;
      rem_d   = rem_q;
      wb_d    = wb_q;
`ifdef ALIGN_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               addr_d  = first_addr;
               step_d  = step_sel;
               pre_d   = pre_i;
               rem_d   = cnt_norm;
               state_d = S_ISSUE;
`ifdef ALIGN_CHECK_EN
               err_d   = misaligned;
               if (misaligned)
                  state_d = S_CHK;
`endif
            end
         end
         S_ISSUE: begin
            if (mem.mem_ack_i) begin
               rem_d = rem_q - CW'(1);
               if (rem_q == CW'(1)) begin
                  // pre mode already points at the final target
                  wb_d    = pre_q ? addr_q : addr_q + step_q;
                  state_d = S_DONE;
               end else begin
                  addr_d = addr_q + step_q;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
`ifdef ALIGN_CHECK_EN
         S_CHK:  state_d = S_DONE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         step_q  <= '0;
         pre_q   <= 1'b0;
         rem_q   <= '0;
         wb_q    <= '0;
`ifdef ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         pre_q   <= pre_d;
         rem_q   <= rem_d;
         wb_q    <= wb_d;
`ifdef ALIGN_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign mem.mem_req_o  = (state_q == S_ISSUE);
   assign mem.mem_addr_o = addr_q;
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign wb_addr_o      = wb_q;

`ifdef ALIGN_CHECK_EN
   assign wb_en_o = done_o && !err_q;
   assign err_o   = done_o && err_q;
`else
   assign wb_en_o = done_o;
   assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_burst_agu.sv
// Randomised self-checking bench for memory_burst_agu.
// Expected addresses come from the closed-form base + k*step sequence.
module tb_memory_burst_agu;

   localparam int WORD = 16;
   localparam int MAXB = 4;
   localparam int CW   = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [WORD-1:0] base;
   logic [WORD-1:0] off;
   logic [2:0]      sel;
   logic            pre;
   logic [CW-1:0]   cnt;
   logic            busy;
   logic            done;
   logic            wb_en;
   logic [WORD-1:0] wb_addr;
   logic            err;

   int tests = 0;
   int fails = 0;

   memory_burst_agu_if #(.WORD(WORD)) bus ();

   memory_burst_agu #(.WORD(WORD), .MAX_BURST(MAXB)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .base_i    (base),
      .offset_i  (off),
      .sel_i     (sel),
      .pre_i     (pre),
      .count_i   (cnt),
      .mem       (bus),
      .busy_o    (busy),
      .done_o    (done),
      .wb_en_o   (wb_en),
      .wb_addr_o (wb_addr),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step_of(input logic [2:0] s, input logic [15:0] o);
      case (s)
         3'd0:    return 16'h0002;
         3'd1:    return 16'h0001;
         3'd2:    return 16'hFFFE;
         3'd3:    return 16'hFFFF;
         3'd4:    return o;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int norm(input int c);
      if (c == 0) return 1;
      if (c > MAXB) return MAXB;
      return c;
   endfunction

   task automatic run_burst(input logic [15:0] b, input logic [15:0] o,
                            input logic [2:0] s, input logic p, input int c,
                            input int mind, input int maxd, input bit noise);
      logic [15:0] st;
      logic [15:0] exp_a[$];
      logic [15:0] exp_wb;
      int n, idx, wl, guard;
      st = step_of(s, o);
      n  = norm(c);
      for (int k = 0; k < n; k++)
         exp_a.push_back(b + st * 16'(p ? k + 1 : k));
      exp_wb = b + st * 16'(n);
      if (noise) begin
         @(negedge clk);
         bus.mem_ack_i = 1'b1;
         @(negedge clk);
         tests++;
         if (bus.mem_req_o !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stray_ack req=%b busy=%b want req=0 busy=0", bus.mem_req_o, busy);
         end
      end
      @(negedge clk);
      base  = b;
      off   = o;
      sel   = s;
      pre   = p;
      cnt   = CW'(c);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bus.mem_ack_i = 1'b0;
      idx   = 0;
      guard = 0;
      wl    = $urandom_range(maxd, mind);
      while (idx < n && guard < 200) begin
         tests++;
         if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_a[idx]) begin
            fails++;
            $display("FAIL access%0d req=%b addr=%h want req=1 addr=%h",
                     idx, bus.mem_req_o, bus.mem_addr_o, exp_a[idx]);
         end
         if (noise) begin
            start = 1'($urandom % 2);
            base  = 16'($urandom);
            sel   = 3'($urandom);
            cnt   = CW'($urandom);
         end
         if (wl > 0) begin
            bus.mem_ack_i = 1'b0;
            wl--;
         end else begin
            bus.mem_ack_i = 1'b1;
            idx++;
            wl = $urandom_range(maxd, mind);
         end
         @(negedge clk);
         guard++;
      end
      bus.mem_ack_i = 1'b0;
      start = 1'b0;
      tests++;
      if (done !== 1'b1 || wb_en !== 1'b1 || wb_addr !== exp_wb || err !== 1'b0 ||
          busy !== 1'b1 || bus.mem_req_o !== 1'b0) begin
         fails++;
         $display("FAIL done done=%b wb_en=%b wb=%h err=%b busy=%b req=%b want 1 1 %h 0 1 0",
                  done, wb_en, wb_addr, err, busy, bus.mem_req_o, exp_wb);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0 || bus.mem_req_o !== 1'b0) begin
         fails++;
         $display("FAIL idle busy=%b done=%b wb_en=%b req=%b want all 0",
                  busy, done, wb_en, bus.mem_req_o);
      end
   endtask

   task automatic check_zero(input string tag);
      tests++;
      if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 16'h0 || busy !== 1'b0 ||
          done !== 1'b0 || wb_en !== 1'b0 || wb_addr !== 16'h0 || err !== 1'b0) begin
         fails++;
         $display("FAIL %s req=%b addr=%h busy=%b done=%b wb_en=%b wb=%h err=%b want all 0",
                  tag, bus.mem_req_o, bus.mem_addr_o, busy, done, wb_en, wb_addr, err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      base  = '0;
      off   = '0;
      sel   = '0;
      pre   = 1'b0;
      cnt   = '0;
      bus.mem_ack_i = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("post_reset");
   endtask

   task automatic test_post_plus2();
      run_burst(16'h1000, 16'h0, 3'd0, 1'b0, 3, 0, 0, 1'b0);
   endtask

   task automatic test_pre_minus1();
      run_burst(16'h0001, 16'h0, 3'd3, 1'b1, 2, 2, 2, 1'b0);
   endtask

   task automatic test_offs();
      run_burst(16'h2000, 16'h0010, 3'd4, 1'b0, 0, 0, 0, 1'b0);
      run_burst(16'h2000, 16'h0010, 3'd4, 1'b1, 7, 0, 1, 1'b0);
      run_burst(16'h4321, 16'h0, 3'd6, 1'b1, 3, 0, 1, 1'b0);
   endtask

   task automatic test_noise();
      run_burst(16'h3000, 16'h0, 3'd1, 1'b0, 4, 0, 2, 1'b1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      base  = 16'h5000;
      sel   = 3'd0;
      pre   = 1'b0;
      cnt   = CW'(4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 16'h5002) begin
         fails++;
         $display("FAIL mid_second req=%b addr=%h want 1 5002", bus.mem_req_o, bus.mem_addr_o);
      end
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("after_mid_reset");
   endtask

   task automatic test_align();
`ifdef ALIGN_CHECK_EN
      @(negedge clk);
      base  = 16'h1001;
      sel   = 3'd0;
      pre   = 1'b0;
      cnt   = CW'(2);
      start = 1'b1;
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (bus.mem_req_o !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL align_c1 req=%b done=%b want 0 0", bus.mem_req_o, done);
      end
      @(negedge clk);
      tests++;
      if (bus.mem_req_o !== 1'b0 || done !== 1'b1 || err !== 1'b1 || wb_en !== 1'b0) begin
         fails++;
         $display("FAIL align_c2 req=%b done=%b err=%b wb_en=%b want 0 1 1 0",
                  bus.mem_req_o, done, err, wb_en);
      end
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL align_idle busy=%b err=%b want 0 0", busy, err);
      end
      run_burst(16'h1001, 16'h0, 3'd1, 1'b0, 2, 0, 0, 1'b0);
`else
      run_burst(16'h1001, 16'h0, 3'd0, 1'b0, 1, 0, 0, 1'b0);
      run_burst(16'h1001, 16'h0, 3'd2, 1'b1, 2, 0, 1, 1'b0);
`endif
   endtask

   task automatic test_random();
      logic [15:0] b;
      logic [2:0]  s;
      for (int i = 0; i < 40; i++) begin
         b = 16'($urandom);
         s = 3'($urandom);
`ifdef ALIGN_CHECK_EN
         if (s == 3'd0 || s == 3'd2) b[0] = 1'b0;
`endif
         run_burst(b, 16'($urandom), s, 1'($urandom), int'($urandom_range(7, 0)),
                   0, 3, 1'(i % 4 == 0));
      end
   endtask

   initial begin
      test_reset();
      test_post_plus2();
      test_pre_minus1();
      test_offs();
      test_noise();
      test_reset_mid();
      test_align();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memory_burst_agu.md
# memory_burst_agu

Multi-cycle address-generation unit for the XMakina data path. It takes a base pointer and a step selection (±2, ±1, register offset, zero) and issues a burst of 1..MAX_BURST memory accesses over a req/ack handshake. The step is applied either before or after each access, and the unit returns the updated pointer for register write-back. It sits between the control unit/register file and the memory interface, and replaces the purely combinational offset selection with a sequenced, auto-stepping access engine.

## Interface
Parameters:
- WORD, 16, address/data-path width in bits
- MAX_BURST, 4, maximum accesses per burst (≥1); CW = $clog2(MAX_BURST+1) is a derived localparam

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  request a burst; sampled only in IDLE
- base_i  in  WORD  starting pointer, captured on accepted start
- offset_i  in  WORD  step used when sel_i = OFFS, captured on accepted start
- sel_i  in  3  step select: 0 PLUS_2 (+2), 1 PLUS_1 (+1), 2 MINUS_2 (−2), 3 MINUS_1 (−1), 4 OFFS (offset_i), 5–7 ZERO (0)
- pre_i  in  1  1 = pre-step (step, then access); 0 = post-step (access, then step)
- count_i  in  CW  number of accesses; 0 treated as 1, values > MAX_BURST saturate to MAX_BURST
- mem_req_o  out  1  access request
- mem_addr_o  out  WORD  access address, valid while mem_req_o = 1
- mem_ack_i  in  1  access complete; meaningful only while mem_req_o = 1
- busy_o  out  1  high in ISSUE and DONE
- done_o  out  1  one-cycle completion pulse
- wb_en_o  out  1  one-cycle write-back strobe, coincident with done_o when no error
- wb_addr_o  out  WORD  final pointer; valid while wb_en_o = 1
- err_o  out  1  misalignment abort flag, coincident with done_o (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: when start_i = 1, capture base, step and pre, and load remaining = normalised count_i. If pre = 1, the first address is base+step; otherwise it is base. Go to ISSUE.
- ISSUE: mem_req_o = 1 and mem_addr_o = the current address. On mem_ack_i, remaining decrements and the pointer advances by step. If remaining becomes 0, go to DONE; otherwise stay in ISSUE with the next address.
- DONE: assert done_o and wb_en_o for one cycle, with wb_addr_o = base + n·step (n = normalised count) for both pre and post modes. Return to IDLE.
- Access address sequences: pre = base+step, base+2·step, …, base+n·step. Post = base, base+step, …, base+(n−1)·step.
- Arithmetic is modulo 2^WORD. Negative steps are two's complement, and wrap-around at 0/0xFFFF is silent.
- ZERO step: all n accesses go to base, and wb_addr_o = base.
- start_i while busy_o = 1 is ignored. mem_ack_i outside ISSUE is ignored.
- Reset (any time, including mid-burst) forces IDLE and drops all outputs immediately.

## Timing
- Reset values: mem_req_o 0, mem_addr_o 0, busy_o 0, done_o 0, wb_en_o 0, wb_addr_o 0, err_o 0.
- All outputs are registered or decoded from state; there is no combinational path from any input to mem_req_o.
- Cycle 0: start accepted. From cycle 1: mem_req_o high. Zero-wait ack is allowed, so each access takes at least 1 cycle.
- With ack held high, an n-access burst has requests in cycles 1..n, done_o/wb_en_o in cycle n+1, and a new start is accepted in cycle n+2.
- mem_addr_o updates in the cycle after the ack that completes the previous access. mem_req_o stays high between accesses of the same burst.

## Configuration
- ALIGN_CHECK_EN defined: checked in the cycle after start. If sel is PLUS_2 or MINUS_2 and the first access address has bit 0 = 1, no request is issued. The FSM goes directly to DONE with done_o = 1, err_o = 1, wb_en_o = 0. Other selections are not checked.
- ALIGN_CHECK_EN undefined: err_o is tied to 0 and misaligned word bursts proceed normally.

## Test plan
- Post, PLUS_2, base 0x1000, count 3, ack always high → addresses 0x1000, 0x1002, 0x1004 in cycles 1–3; done_o/wb_en_o in cycle 4 with wb_addr_o = 0x1006.
- Pre, MINUS_1, base 0x0001, count 2, ack delayed 2 cycles per access → addresses 0x0000 then 0xFFFF, each held until ack; wb_addr_o = 0xFFFF.
- OFFS, offset 0x0010, count 0, post, base 0x2000 → single access at 0x2000; wb_addr_o = 0x2010. Also count = 7 with MAX_BURST = 4 → exactly 4 accesses.
- Burst in progress with start_i pulsed and stray mem_ack_i before start → extra start ignored, access count unchanged; reset asserted during second access → mem_req_o drops immediately, all outputs 0.
- ALIGN_CHECK_EN defined, PLUS_2, base 0x1001 → no mem_req_o; cycle 2 has done_o = 1, err_o = 1, wb_en_o = 0. Same stimulus without the macro → access at 0x1001, err_o = 0.
